// File: rtl/pixel_pkg.sv
// -----------------------------------------------------------------------------
// pixel_pkg
// Shared types and constants for the result-frame pixel path.
//   PIX_W          width of one packed {R,G,B} BRAM word
//   FRAME_W/H      default frame geometry (160 x 119)
//   FRAME_PIXELS   words per default frame
//   wr_state_e     writer FSM states
//   pixel_t        one pixel as three 8-bit channels
//   pack_pixel()   flattens a pixel_t into the BRAM word layout {R,G,B}
// -----------------------------------------------------------------------------
package pixel_pkg;

  localparam int PIX_W        = 24;
  localparam int FRAME_W      = 160;
  localparam int FRAME_H      = 119;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  function automatic logic [PIX_W-1:0] pack_pixel(input pixel_t p);
    return {p.r, p.g, p.b};
  endfunction

endpackage

// File: rtl/pixel_skid_buf.sv
// -----------------------------------------------------------------------------
// pixel_skid_buf
// Two-entry FIFO between the image processor and the BRAM write port.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset (control only)
//   flush_i          synchronous discard of all queued entries
//   in_valid_i       offered pixel; pushed when in_valid_i & in_ready_o
//   in_data_i        offered pixel data
//   in_ready_o       not full; comes straight from the occupancy register
//   pop_i            consume head entry (ignored when empty)
//   out_valid_o      head entry present
//   out_data_o       head entry data
// -----------------------------------------------------------------------------
module pixel_skid_buf
  import pixel_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   flush_i,
  input  logic   in_valid_i,
  input  pixel_t in_data_i,
  output logic   in_ready_o,
  input  logic   pop_i,
  output logic   out_valid_o,
  output pixel_t out_data_o
);

  pixel_t     mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];

  assign push = in_valid_i && in_ready_o;
  assign pop  = pop_i && out_valid_o;

  // Push and pop in the same cycle leave occupancy unchanged, so a steady
  // one-pixel-per-cycle stream never sees ready drop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/frame_bram_writer.sv
// -----------------------------------------------------------------------------
// frame_bram_writer
// Sink of the pixel path: writes one frame of processed pixels, raster order,
// into port A of the 24-bit result BRAM for every start pulse.
// Optional feature macro: FRAME_WRITER_CHECKSUM_EN (frame checksum adder).
// Ports:
//   clk                  system clock, rising edge
//   reset                asynchronous, active-low
//   start                one-cycle arm request, honoured only when idle
//   R_in/G_in/B_in       pixel channels from the image processor
//   done_in              pixel valid; taken when done_in & ready_out
//   ready_out            writer can take a pixel this cycle
//   wr_stall             BRAM port busy, hold off writes
//   ena/wea              BRAM enable / write enable (identical)
//   addra/dina           BRAM write address / data {R,G,B}
//   busy                 frame in progress
//   frame_done           one-cycle pulse after the last word is written
//   drop_err             sticky: pixel arrived while not armed
//   checksum             16-bit sum of R+G+B over the frame (0 if disabled)
// -----------------------------------------------------------------------------
module frame_bram_writer #(
  parameter int FRAME_W   = pixel_pkg::FRAME_W,
  parameter int FRAME_H   = pixel_pkg::FRAME_H,
  parameter int ADDR_W    = 15,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        R_in,
  input  logic [7:0]        G_in,
  input  logic [7:0]        B_in,
  input  logic              done_in,
  output logic              ready_out,
  input  logic              wr_stall,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [23:0]       dina,
  output logic              busy,
  output logic              frame_done,
  output logic              drop_err,
  output logic [15:0]       checksum
);

  import pixel_pkg::*;

  localparam int NPIX  = FRAME_W * FRAME_H;
  localparam int CNT_W = $clog2(NPIX + 1);

  // The whole frame must fit in the address space above BASE_ADDR.
  generate
    if (BASE_ADDR + NPIX - 1 > (1 << ADDR_W) - 1) begin : g_addr_range_err
      $error("frame_bram_writer: BASE_ADDR + FRAME_W*FRAME_H - 1 exceeds %0d-bit address space", ADDR_W);
    end
  endgenerate

  wr_state_e          state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ena_q;
  logic [ADDR_W-1:0]  addra_q, addra_d;
  logic [PIX_W-1:0]   dina_q, dina_d;
  logic               frame_done_q;
  logic               drop_err_q, drop_err_d;

  logic               armed, start_acc, issue, last_word;
  logic               buf_ready, buf_valid;
  pixel_t             pix_in, buf_head;

  assign pix_in = '{r: R_in, g: G_in, b: B_in};

  // Last-word flush drops anything queued beyond the frame so it cannot leak
  // into the next one.
  pixel_skid_buf u_skid (
    .clk_i       (clk),
    .rst_ni      (reset),
    .flush_i     (last_word),
    .in_valid_i  (done_in && armed),
    .in_data_i   (pix_in),
    .in_ready_o  (buf_ready),
    .pop_i       (issue),
    .out_valid_o (buf_valid),
    .out_data_o  (buf_head)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)     state_d = WRITE;
      WRITE:   if (last_word) state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // FSM: outputs and write strobes
  always_comb begin
    armed     = (state_q == WRITE);
    start_acc = (state_q == IDLE) && start;
    ready_out = armed && buf_ready;
    busy      = (state_q != IDLE);
    issue     = armed && buf_valid && !wr_stall;
    last_word = issue && (count_q == CNT_W'(NPIX - 1));
  end

  always_comb begin
    count_d = count_q;
    addra_d = addra_q;
    dina_d  = dina_q;
    if (issue) begin
      addra_d = ADDR_W'(BASE_ADDR) + ADDR_W'(count_q);
      dina_d  = pack_pixel(buf_head);
      count_d = last_word ? '0 : count_q + 1'b1;
    end
    // A set in the same cycle as start wins: that pixel is still discarded.
    drop_err_d = (drop_err_q && !start_acc) || (done_in && !armed);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q      <= '0;
      ena_q        <= 1'b0;
      addra_q      <= ADDR_W'(BASE_ADDR);
      dina_q       <= '0;
      frame_done_q <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      ena_q        <= issue;
      addra_q      <= addra_d;
      dina_q       <= dina_d;
      frame_done_q <= (state_q == DONE);
      drop_err_q   <= drop_err_d;
    end
  end

  assign ena        = ena_q;
  assign wea        = ena_q;
  assign addra      = addra_q;
  assign dina       = dina_q;
  assign frame_done = frame_done_q;
  assign drop_err   = drop_err_q;

`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  // start and issue are mutually exclusive (IDLE vs WRITE).
  always_comb begin
    csum_d = csum_q;
    if (start_acc)  csum_d = '0;
    else if (issue) csum_d = csum_q + 16'(buf_head.r) + 16'(buf_head.g) + 16'(buf_head.b);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_bram_writer.sv
module tb_frame_bram_writer;

  localparam int NPIX = 160 * 119;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, done_in, wr_stall;
  logic [7:0]  R_in, G_in, B_in;
  logic        ready_out, ena, wea, busy, frame_done, drop_err;
  logic [14:0] addra;
  logic [23:0] dina;
  logic [15:0] checksum;

  frame_bram_writer dut (
    .clk(clk), .reset(reset), .start(start),
    .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .done_in(done_in), .ready_out(ready_out), .wr_stall(wr_stall),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .busy(busy), .frame_done(frame_done), .drop_err(drop_err),
    .checksum(checksum)
  );

  // 2x2 frame instance for the checksum trial
  logic        s_start, s_done_in;
  logic        s_ready, s_ena, s_wea, s_busy, s_fd, s_drop;
  logic [14:0] s_addra;
  logic [23:0] s_dina;
  logic [15:0] s_csum;

  frame_bram_writer #(.FRAME_W(2), .FRAME_H(2)) dut_s (
    .clk(clk), .reset(reset), .start(s_start),
    .R_in(8'h01), .G_in(8'h02), .B_in(8'h03),
    .done_in(s_done_in), .ready_out(s_ready), .wr_stall(1'b0),
    .ena(s_ena), .wea(s_wea), .addra(s_addra), .dina(s_dina),
    .busy(s_busy), .frame_done(s_fd), .drop_err(s_drop),
    .checksum(s_csum)
  );

  int tests = 0;
  int fails = 0;
  int fd_seen = 0;

  // Reference model: phase 0 idle, 1 armed, 2 frame complete
  int          m_st;
  logic [23:0] m_q[$];
  int          m_cnt;
  bit          m_drop;
  logic [15:0] m_sum;
  bit          e_ena, e_fd;
  logic [14:0] e_addr;
  logic [23:0] e_dina;
  int          pix_idx;
  logic [23:0] pix;
  bit          rand_data;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_q.delete(); m_cnt = 0; m_drop = 1'b0; m_sum = '0;
    e_ena = 1'b0; e_fd = 1'b0; e_addr = '0; e_dina = '0;
  endtask

  task automatic compare();
    if (frame_done === 1'b1) fd_seen++;
    check("ena", ena, e_ena);
    check("wea", wea, e_ena);
    check("addra", addra, e_addr);
    check("dina", dina, e_dina);
    check("ready_out", ready_out, (m_st == 1) && (m_q.size() < 2));
    check("busy", busy, m_st != 0);
    check("frame_done", frame_done, e_fd);
    check("drop_err", drop_err, m_drop);
`ifdef FRAME_WRITER_CHECKSUM_EN
    check("checksum", checksum, m_sum);
`else
    check("checksum", checksum, 16'h0000);
`endif
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance the model
  // over the next rising edge, then wait for the next falling edge.
  task automatic drive(input bit st, input bit dv, input bit stall);
    bit rdy, wr;
    compare();
    start = st; done_in = dv; wr_stall = stall;
    {R_in, G_in, B_in} = pix;
    rdy  = (m_st == 1) && (m_q.size() < 2);
    wr   = (m_st == 1) && (m_q.size() > 0) && !stall;
    e_ena = wr;
    e_fd  = (m_st == 2);
    if (wr) begin
      e_addr = m_cnt[14:0];
      e_dina = m_q.pop_front();
      m_sum  = m_sum + e_dina[23:16] + e_dina[15:8] + e_dina[7:0];
      m_cnt++;
    end
    if (dv && rdy) begin
      m_q.push_back(pix);
      pix_idx++;
      pix = rand_data ? 24'($urandom) : 24'(pix_idx);
    end
    if (st && m_st == 0) m_drop = 1'b0;
    if (dv && m_st != 1) m_drop = 1'b1;
    case (m_st)
      0: if (st) begin m_st = 1; m_sum = '0; end
      1: if (wr && m_cnt == NPIX) begin m_st = 2; m_cnt = 0; m_q.delete(); end
      default: m_st = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic new_frame(input bit rnd);
    rand_data = rnd;
    pix_idx = 0;
    pix = rnd ? 24'($urandom) : 24'd0;
    drive(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    reset = 1'b0; start = 1'b0; done_in = 1'b0; wr_stall = 1'b0;
    {R_in, G_in, B_in} = '0;
    s_start = 1'b0; s_done_in = 1'b0;
    pix = '0; pix_idx = 0; rand_data = 1'b0;
    model_reset();

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      {R_in, G_in, B_in} = 24'($urandom);
      done_in = 1'($urandom); start = 1'($urandom); wr_stall = 1'($urandom);
      @(negedge clk);
      compare();
    end
    start = 1'b0; done_in = 1'b0; wr_stall = 1'b0;
    reset = 1'b1;

    // Pixel while idle sets drop_err; the next start clears it
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // Frame 1: full rate, no stall, dina = pixel index
    new_frame(1'b0);
    for (int c = 0; c < NPIX + 4; c++) drive(1'b0, pix_idx < NPIX, 1'b0);
    check("fd_count_frame1", fd_seen, 1);

    // Frame 2: stall burst with continuous input, then random until pixel 500
    new_frame(1'b1);
    repeat (3) drive(1'b0, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b1, 1'b1);
    repeat (2) drive(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 5000 && m_cnt < 500; c++)
      drive(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);

    // Asynchronous reset mid-frame
    compare();
    reset = 1'b0;
    #1;
    check("ena_async_rst", ena, 1'b0);
    check("addra_async_rst", addra, 15'd0);
    check("busy_async_rst", busy, 1'b0);
    model_reset();
    done_in = 1'b0; start = 1'b0; wr_stall = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // Frame 3: restart from address 0 with random data, rate and stalls
    new_frame(1'b1);
    for (int c = 0; c < 40000 && m_st != 0; c++)
      drive(1'b0, (pix_idx < NPIX) && ($urandom_range(0, 15) != 0), $urandom_range(0, 15) == 0);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    check("fd_count_total", fd_seen, 2);

    // Checksum trial on the 2x2 instance, every pixel 0x010203
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    acc = 0;
    for (int c = 0; c < 20 && s_fd !== 1'b1; c++) begin
      s_done_in = (acc < 4) && (s_ready === 1'b1);
      if (s_done_in) acc++;
      @(negedge clk);
    end
    s_done_in = 1'b0;
    check("small_frame_done", s_fd, 1'b1);
    check("small_busy", s_busy, 1'b0);
    check("small_last_addr", s_addra, 15'd3);
    check("small_last_dina", s_dina, 24'h010203);
    check("small_ena", s_ena, 1'b0);
    check("small_wea", s_wea, 1'b0);
    check("small_drop", s_drop, 1'b0);
`ifdef FRAME_WRITER_CHECKSUM_EN
    check("small_checksum", s_csum, 16'h0018);
`else
    check("small_checksum", s_csum, 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
